tlb_unit: RTL and testbench

- Joint TLB (JTLB) shared by fetch and memory stages.
- Translates the instruction and data virtual addresses to physical addresses.
- Produces the TLB refill/invalid/modify flags consumed by the CP0/exception stage.
- Executes TLBP/TLBR/TLBWI/TLBWR: reads EntryHi/EntryLo0/EntryLo1/PageMask/Index/Random from CP0 and returns probe/read results to it in the same cycle.

---
 rtl/tlb_pkg.sv | 43 ++++
 rtl/tlb_unit_if.sv | 41 ++++
 rtl/tlb_lookup.sv | 52 +++++
 rtl/tlb_unit.sv | 187 ++++++++++++++++++
 tb/tb_tlb_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the joint TLB.
// CP0 field positions, segment codes and the entry layout.
package tlb_pkg;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;
    localparam logic [2:0] CACHE_UNCACHED = 3'd2;

    localparam int VPN2_HI = 31;
    localparam int VPN2_LO = 13;
    localparam int ASID_HI = 7;
    localparam int ASID_LO = 0;
    localparam int PFN_HI  = 25;
    localparam int PFN_LO  = 6;
    localparam int C_HI    = 5;
    localparam int C_LO    = 3;
    localparam int D_BIT   = 2;
    localparam int V_BIT   = 1;
    localparam int G_BIT   = 0;
    localparam int MASK_HI = 24;
    localparam int MASK_LO = 13;
    localparam int P_BIT   = 31;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    function automatic logic is_mapped(input logic [31:0] va);
        return (va[31:29] != KSEG0) && (va[31:29] != KSEG1);
    endfunction

endpackage

// File: rtl/tlb_unit_if.sv
// Fetch/data translation bus between the pipeline and the TLB.
// master = pipeline side, slave = TLB side.
interface tlb_unit_if;

    logic        inst_en;
    logic [31:0] inst_vaddr;
    logic [31:0] inst_paddr;
    logic        inst_uncached;
    logic        inst_tlb_refill;
    logic        inst_tlb_invalid;

    logic        data_en;
    logic        data_write;
    logic [31:0] data_vaddr;
    logic [31:0] data_paddr;
    logic        data_uncached;
    logic        data_tlb_refill;
    logic        data_tlb_invalid;
    logic        data_tlb_modify;

    modport master (
        output inst_en, inst_vaddr,
        output data_en, data_write, data_vaddr,
        input  inst_paddr, inst_uncached,
        input  inst_tlb_refill, inst_tlb_invalid,
        input  data_paddr, data_uncached,
        input  data_tlb_refill, data_tlb_invalid,
        input  data_tlb_modify
    );

    modport slave (
        input  inst_en, inst_vaddr,
        input  data_en, data_write, data_vaddr,
        output inst_paddr, inst_uncached,
        output inst_tlb_refill, inst_tlb_invalid,
        output data_paddr, data_uncached,
        output data_tlb_refill, data_tlb_invalid,
        output data_tlb_modify
    );

endinterface

// File: rtl/tlb_lookup.sv
// Combinational associative match over all TLB entries.
// Lowest matching index wins; odd_i picks the odd page.
module tlb_lookup
    import tlb_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  tlb_entry_t [N-1:0] entries_i,
    input  logic [18:0]        vpn2_i,
    input  logic [7:0]         asid_i,
    input  logic               odd_i,
    output logic               hit_o,
    output logic [IW-1:0]      idx_o,
    output logic [19:0]        pfn_o,
    output logic [2:0]         c_o,
    output logic               d_o,
    output logic               v_o
);

    logic unused_mask;

    // Scan downward so the lowest matching entry is the last one kept.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pfn_o = '0;
        c_o   = '0;
        d_o   = 1'b0;
        v_o   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (entries_i[i].vpn2 == vpn2_i &&
                (entries_i[i].g || entries_i[i].asid == asid_i)) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
                pfn_o = odd_i ? entries_i[i].pfn1 : entries_i[i].pfn0;
                c_o   = odd_i ? entries_i[i].c1 : entries_i[i].c0;
                d_o   = odd_i ? entries_i[i].d1 : entries_i[i].d0;
                v_o   = odd_i ? entries_i[i].v1 : entries_i[i].v0;
            end
        end
    end

    // Page mask is carried for TLBR only; matching is fixed at 4 KB.
    always_comb begin
        unused_mask = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_mask = unused_mask ^ (^entries_i[i].mask);
        end
    end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: fetch/data translation, TLBP/TLBR results to CP0
// and TLBWI/TLBWR entry writes.
module tlb_unit
    import tlb_pkg::*;
#(
    parameter int TLB_LINE_NUM = 16,
    parameter int INDEX_W      = $clog2(TLB_LINE_NUM)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [3:0]  tlb_type,
    input  logic [31:0] entry_hi_W,
    input  logic [31:0] page_mask_W,
    input  logic [31:0] entry_lo0_W,
    input  logic [31:0] entry_lo1_W,
    input  logic [31:0] index_W,
    input  logic [31:0] random_W,
    input  logic [2:0]  config_k0,
    tlb_unit_if.slave   bus,
    output logic [31:0] index_in,
    output logic [31:0] entry_hi_in,
    output logic [31:0] page_mask_in,
    output logic [31:0] entry_lo0_in,
    output logic [31:0] entry_lo1_in
);

    tlb_entry_t [TLB_LINE_NUM-1:0] tlb_q, tlb_d;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_idx;
    tlb_entry_t         wr_entry;
    tlb_entry_t         rd_entry;
    logic [7:0]         cur_asid;

    logic               i_hit, d_hit, p_hit;
    logic [INDEX_W-1:0] i_idx, d_idx, p_idx;
    logic [19:0]        i_pfn, d_pfn, p_pfn;
    logic [2:0]         i_c, d_c, p_c;
    logic               i_d, d_d, p_d;
    logic               i_v, d_v, p_v;
    logic               i_map, d_map;
    logic               unused_ok;

    assign cur_asid = entry_hi_W[ASID_HI:ASID_LO];
    assign wr_en    = !stall && (tlb_type[3] || tlb_type[2]);
    assign wr_idx   = tlb_type[2] ? index_W[INDEX_W-1:0]
                                  : random_W[INDEX_W-1:0];

    // Assemble the entry image from the CP0 write registers.
    always_comb begin
        wr_entry      = '0;
        wr_entry.vpn2 = entry_hi_W[VPN2_HI:VPN2_LO];
        wr_entry.asid = cur_asid;
        wr_entry.mask = page_mask_W[MASK_HI:MASK_LO];
        wr_entry.g    = entry_lo0_W[G_BIT] & entry_lo1_W[G_BIT];
        wr_entry.pfn0 = entry_lo0_W[PFN_HI:PFN_LO];
        wr_entry.c0   = entry_lo0_W[C_HI:C_LO];
        wr_entry.d0   = entry_lo0_W[D_BIT];
        wr_entry.v0   = entry_lo0_W[V_BIT];
        wr_entry.pfn1 = entry_lo1_W[PFN_HI:PFN_LO];
        wr_entry.c1   = entry_lo1_W[C_HI:C_LO];
        wr_entry.d1   = entry_lo1_W[D_BIT];
        wr_entry.v1   = entry_lo1_W[V_BIT];
    end

    // Next-state of the entry array: one entry replaced per write.
    always_comb begin
        tlb_d = tlb_q;
        if (wr_en) begin
            tlb_d[wr_idx] = wr_entry;
        end
    end

    // Entry storage; reset clears every field and flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tlb_q <= '0;
        end else begin
            tlb_q <= tlb_d;
        end
    end

    tlb_lookup #(.N(TLB_LINE_NUM), .IW(INDEX_W)) u_inst_lk (
        .entries_i (tlb_q),
        .vpn2_i    (bus.inst_vaddr[VPN2_HI:VPN2_LO]),
        .asid_i    (cur_asid),
        .odd_i     (bus.inst_vaddr[12]),
        .hit_o     (i_hit),
        .idx_o     (i_idx),
        .pfn_o     (i_pfn),
        .c_o       (i_c),
        .d_o       (i_d),
        .v_o       (i_v)
    );

    tlb_lookup #(.N(TLB_LINE_NUM), .IW(INDEX_W)) u_data_lk (
        .entries_i (tlb_q),
        .vpn2_i    (bus.data_vaddr[VPN2_HI:VPN2_LO]),
        .asid_i    (cur_asid),
        .odd_i     (bus.data_vaddr[12]),
        .hit_o     (d_hit),
        .idx_o     (d_idx),
        .pfn_o     (d_pfn),
        .c_o       (d_c),
        .d_o       (d_d),
        .v_o       (d_v)
    );

    tlb_lookup #(.N(TLB_LINE_NUM), .IW(INDEX_W)) u_probe_lk (
        .entries_i (tlb_q),
        .vpn2_i    (entry_hi_W[VPN2_HI:VPN2_LO]),
        .asid_i    (cur_asid),
        .odd_i     (1'b0),
        .hit_o     (p_hit),
        .idx_o     (p_idx),
        .pfn_o     (p_pfn),
        .c_o       (p_c),
        .d_o       (p_d),
        .v_o       (p_v)
    );

    assign i_map = is_mapped(bus.inst_vaddr);
    assign d_map = is_mapped(bus.data_vaddr);

    // Fetch port: segment decode, translation and exception flags.
    always_comb begin
        bus.inst_paddr       = '0;
        bus.inst_uncached    = 1'b0;
        bus.inst_tlb_refill  = 1'b0;
        bus.inst_tlb_invalid = 1'b0;
        if (!i_map) begin
            bus.inst_paddr    = {3'b000, bus.inst_vaddr[28:0]};
            bus.inst_uncached = (bus.inst_vaddr[31:29] == KSEG1) ||
                                (config_k0 == CACHE_UNCACHED);
        end else if (i_hit) begin
            bus.inst_paddr    = {i_pfn, bus.inst_vaddr[11:0]};
            bus.inst_uncached = (i_c == CACHE_UNCACHED);
        end
        if (bus.inst_en && i_map) begin
            bus.inst_tlb_refill  = !i_hit;
            bus.inst_tlb_invalid = i_hit && !i_v;
        end
    end

    // Data port: as fetch, plus the store-to-clean-page modify flag.
    always_comb begin
        bus.data_paddr       = '0;
        bus.data_uncached    = 1'b0;
        bus.data_tlb_refill  = 1'b0;
        bus.data_tlb_invalid = 1'b0;
        bus.data_tlb_modify  = 1'b0;
        if (!d_map) begin
            bus.data_paddr    = {3'b000, bus.data_vaddr[28:0]};
            bus.data_uncached = (bus.data_vaddr[31:29] == KSEG1) ||
                                (config_k0 == CACHE_UNCACHED);
        end else if (d_hit) begin
            bus.data_paddr    = {d_pfn, bus.data_vaddr[11:0]};
            bus.data_uncached = (d_c == CACHE_UNCACHED);
        end
        if (bus.data_en && d_map) begin
            bus.data_tlb_refill  = !d_hit;
            bus.data_tlb_invalid = d_hit && !d_v;
            bus.data_tlb_modify  = d_hit && d_v && !d_d &&
                                   bus.data_write;
        end
    end

    // TLBP result and TLBR read-back, always live.
    always_comb begin
        rd_entry     = tlb_q[index_W[INDEX_W-1:0]];
        index_in     = p_hit ? 32'(p_idx) : (32'd1 << P_BIT);
        entry_hi_in  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
        page_mask_in = {7'b0, rd_entry.mask, 13'b0};
        entry_lo0_in = {6'b0, rd_entry.pfn0, rd_entry.c0,
                        rd_entry.d0, rd_entry.v0, rd_entry.g};
        entry_lo1_in = {6'b0, rd_entry.pfn1, rd_entry.c1,
                        rd_entry.d1, rd_entry.v1, rd_entry.g};
    end

    assign unused_ok = ^{entry_hi_W[12:8], page_mask_W[31:25],
                         page_mask_W[12:0], entry_lo0_W[31:26],
                         entry_lo1_W[31:26], index_W[31:INDEX_W],
                         random_W[31:INDEX_W], tlb_type[1:0],
                         i_idx, d_idx, p_pfn, p_c, p_d, p_v};

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: translation, flags, TLBP/TLBR,
// TLBWI/TLBWR with stall, kseg0/kseg1 decode.
module tb_tlb_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [3:0]  tlb_type;
    logic [31:0] entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W;
    logic [31:0] index_W, random_W;
    logic [2:0]  config_k0;
    logic [31:0] index_in, entry_hi_in, page_mask_in;
    logic [31:0] entry_lo0_in, entry_lo1_in;

    int checks = 0;
    int errors = 0;

    tlb_unit_if bus ();

    tlb_unit #(.TLB_LINE_NUM(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .tlb_type     (tlb_type),
        .entry_hi_W   (entry_hi_W),
        .page_mask_W  (page_mask_W),
        .entry_lo0_W  (entry_lo0_W),
        .entry_lo1_W  (entry_lo1_W),
        .index_W      (index_W),
        .random_W     (random_W),
        .config_k0    (config_k0),
        .bus          (bus.slave),
        .index_in     (index_in),
        .entry_hi_in  (entry_hi_in),
        .page_mask_in (page_mask_in),
        .entry_lo0_in (entry_lo0_in),
        .entry_lo1_in (entry_lo1_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h exp %08h", tag, got, exp);
        end
    endtask

    task automatic tlbw(input logic [3:0] ty, input logic [31:0] idx,
                        input logic [31:0] hi, input logic [31:0] lo0,
                        input logic [31:0] lo1);
        tlb_type    = ty;
        index_W     = idx;
        random_W    = idx;
        entry_hi_W  = hi;
        entry_lo0_W = lo0;
        entry_lo1_W = lo1;
        @(posedge clk);
        #1;
        tlb_type = 4'b0000;
    endtask

    task automatic dacc(input logic [31:0] va, input logic wr);
        bus.data_en    = 1'b1;
        bus.data_write = wr;
        bus.data_vaddr = va;
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        tlb_type       = 4'b0000;
        entry_hi_W     = '0;
        page_mask_W    = '0;
        entry_lo0_W    = '0;
        entry_lo1_W    = '0;
        index_W        = '0;
        random_W       = '0;
        config_k0      = 3'd3;
        bus.inst_en    = 1'b0;
        bus.inst_vaddr = '0;
        bus.data_en    = 1'b0;
        bus.data_write = 1'b0;
        bus.data_vaddr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;

        // Reset: every mapped access misses
        bus.inst_en    = 1'b1;
        bus.inst_vaddr = 32'h0040_0000;
        #1;
        chk("rst_i_refill", 32'(bus.inst_tlb_refill), 32'd1);
        chk("rst_i_inval", 32'(bus.inst_tlb_invalid), 32'd0);
        chk("rst_i_paddr", bus.inst_paddr, 32'h0);
        chk("rst_tlbr_lo0", entry_lo0_in, 32'h0);
        bus.inst_vaddr = 32'hBFC0_0000;
        #1;
        chk("k1_i_paddr", bus.inst_paddr, 32'h1FC0_0000);
        chk("k1_i_unc", 32'(bus.inst_uncached), 32'd1);
        chk("k1_i_refill", 32'(bus.inst_tlb_refill), 32'd0);
        bus.inst_en    = 1'b0;
        bus.inst_vaddr = 32'h0040_0000;
        #1;
        chk("noen_refill", 32'(bus.inst_tlb_refill), 32'd0);

        // TLBWI entry 3: even PFN 0x40 V D G, odd PFN 0x80 C=2 V=0 G
        tlbw(4'b0100, 32'd3, 32'h0040_0005, 32'h0000_1007,
             32'h0000_2011);
        dacc(32'h0040_0ABC, 1'b0);
        chk("ld_even_paddr", bus.data_paddr, 32'h0004_0ABC);
        chk("ld_even_flags", {29'b0, bus.data_tlb_refill,
            bus.data_tlb_invalid, bus.data_tlb_modify}, 32'h0);
        chk("ld_even_unc", 32'(bus.data_uncached), 32'd0);
        dacc(32'h0040_1000, 1'b0);
        chk("ld_odd_inval", 32'(bus.data_tlb_invalid), 32'd1);
        chk("ld_odd_refill", 32'(bus.data_tlb_refill), 32'd0);
        chk("ld_odd_paddr", bus.data_paddr, 32'h0008_0000);
        chk("ld_odd_unc", 32'(bus.data_uncached), 32'd1);
        dacc(32'h0040_1000, 1'b1);
        chk("st_odd_mod", 32'(bus.data_tlb_modify), 32'd0);

        // Clean even page: store raises modify, load does not
        tlbw(4'b0100, 32'd3, 32'h0040_0005, 32'h0000_1003,
             32'h0000_2011);
        dacc(32'h0040_0000, 1'b1);
        chk("st_clean_mod", 32'(bus.data_tlb_modify), 32'd1);
        chk("st_clean_inv", 32'(bus.data_tlb_invalid), 32'd0);
        dacc(32'h0040_0000, 1'b0);
        chk("ld_clean_mod", 32'(bus.data_tlb_modify), 32'd0);

        // Non-global entry, ASID 5: probe and lookup by ASID
        tlbw(4'b0100, 32'd3, 32'h0040_0005, 32'h0000_1002,
             32'h0000_2011);
        entry_hi_W = 32'h0040_0006;
        #1;
        chk("tlbp_miss", index_in, 32'h8000_0000);
        dacc(32'h0040_0010, 1'b0);
        chk("asid_refill", 32'(bus.data_tlb_refill), 32'd1);
        entry_hi_W = 32'h0040_0005;
        #1;
        chk("tlbp_hit3", index_in, 32'd3);
        chk("asid_hit_paddr", bus.data_paddr, 32'h0004_0010);

        // Duplicate at entry 1: lowest index wins
        tlbw(4'b0100, 32'd1, 32'h0040_0005, 32'h0000_3003,
             32'h0000_2011);
        #1;
        chk("tlbp_dup", index_in, 32'd1);
        chk("dup_paddr", bus.data_paddr, 32'h000C_0010);

        // TLBWR to 9 held off by stall
        page_mask_W = 32'h0001_E000;
        stall       = 1'b1;
        tlbw(4'b1000, 32'd9, 32'h1234_602A, 32'h0012_345F,
             32'h0056_789D);
        chk("stall_hi", entry_hi_in, 32'h0);
        chk("stall_lo0", entry_lo0_in, 32'h0);
        stall = 1'b0;
        tlbw(4'b1000, 32'd9, 32'h1234_602A, 32'h0012_345F,
             32'h0056_789D);
        chk("tlbr_hi", entry_hi_in, 32'h1234_602A);
        chk("tlbr_mask", page_mask_in, 32'h0001_E000);
        chk("tlbr_lo0", entry_lo0_in, 32'h0012_345F);
        chk("tlbr_lo1", entry_lo1_in, 32'h0056_789D);
        dacc(32'h1234_6ABC, 1'b0);
        chk("wr_paddr", bus.data_paddr, 32'h048D_1ABC);

        // Both write bits: TLBWI index wins over Random
        tlb_type    = 4'b1100;
        index_W     = 32'd2;
        random_W    = 32'd5;
        entry_hi_W  = 32'h0080_0001;
        entry_lo0_W = 32'h0000_0047;
        entry_lo1_W = 32'h0000_0047;
        @(posedge clk);
        #1;
        tlb_type = 4'b0000;
        chk("both_wi_hi", entry_hi_in, 32'h0080_0001);
        index_W = 32'd5;
        #1;
        chk("both_wr_hi", entry_hi_in, 32'h0);

        // kseg0 cache attribute
        config_k0 = 3'd2;
        dacc(32'h8000_1000, 1'b0);
        chk("k0_unc2", 32'(bus.data_uncached), 32'd1);
        chk("k0_paddr", bus.data_paddr, 32'h0000_1000);
        chk("k0_refill", 32'(bus.data_tlb_refill), 32'd0);
        config_k0 = 3'd3;
        #1;
        chk("k0_unc3", 32'(bus.data_uncached), 32'd0);

        // Asynchronous reset clears the array
        index_W = 32'd9;
        rst     = 1'b0;
        #1;
        chk("arst_hi", entry_hi_in, 32'h0);
        chk("arst_refill", 32'(bus.data_tlb_refill), 32'd0);
        dacc(32'h1234_6ABC, 1'b0);
        chk("arst_miss", 32'(bus.data_tlb_refill), 32'd1);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
